calc_key_engine: RTL and testbench



---
 rtl/calc_pkg.sv | 65 ++++++
 rtl/calc_alu.sv | 45 ++++
 rtl/calc_key_engine.sv | 215 +++++++++++++++++++++
 tb/tb_calc_key_engine.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/calc_pkg.sv
// Shared types for the keypad calculator: key codes, operator and state encodings,
// and the key decoder used by calc_key_engine.
package calc_pkg;

    localparam logic [4:0] KEY_ADD = 5'h10;
    localparam logic [4:0] KEY_MUL = 5'h11;
    localparam logic [4:0] KEY_AND = 5'h12;
    localparam logic [4:0] KEY_EXE = 5'h13;
    localparam logic [4:0] KEY_SUB = 5'h14;
    localparam logic [4:0] KEY_OR  = 5'h15;
    localparam logic [4:0] KEY_CE  = 5'h16;
    localparam logic [4:0] KEY_CLR = 5'h17;

    typedef enum logic [2:0] {
        OP_NONE = 3'd0,
        OP_ADD  = 3'd1,
        OP_SUB  = 3'd2,
        OP_MUL  = 3'd3,
        OP_AND  = 3'd4,
        OP_OR   = 3'd5
    } op_t;

    typedef enum logic [2:0] {
        S_A    = 3'd0,
        S_B    = 3'd1,
        S_CALC = 3'd2,
        S_RES  = 3'd3,
        S_ERR  = 3'd4
    } state_t;

    typedef struct packed {
        logic       is_digit;
        logic       is_op;
        logic       is_exe;
        logic       is_ce;
        logic       is_clr;
        logic [3:0] digit;
        op_t        op;
    } key_dec_t;

    function automatic op_t key_to_op(input logic [4:0] code);
        case (code)
            KEY_ADD: return OP_ADD;
            KEY_SUB: return OP_SUB;
            KEY_MUL: return OP_MUL;
            KEY_AND: return OP_AND;
            KEY_OR:  return OP_OR;
            default: return OP_NONE;
        endcase
    endfunction

    // Codes 0x18-0x1F decode to nothing and are therefore ignored.
    function automatic key_dec_t decode_key(input logic [4:0] code);
        key_dec_t k;
        k.digit    = code[3:0];
        k.op       = key_to_op(code);
        k.is_digit = ~code[4];
        k.is_op    = (k.op != OP_NONE);
        k.is_exe   = (code == KEY_EXE);
        k.is_ce    = (code == KEY_CE);
        k.is_clr   = (code == KEY_CLR);
        return k;
    endfunction

endpackage

// File: rtl/calc_alu.sv
// Combinational two-operand ALU; overflow is carry, borrow, or any nonzero
// high product bit depending on the operator.
module calc_alu
    import calc_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  op_t              op_i,
    output logic [WIDTH-1:0] result_o,
    output logic             ovf_o
);

    logic [WIDTH:0]     sum;
    logic [WIDTH:0]     diff;
    logic [2*WIDTH-1:0] prod;

    assign sum  = {1'b0, a_i} + {1'b0, b_i};
    assign diff = {1'b0, a_i} - {1'b0, b_i};
    assign prod = {{WIDTH{1'b0}}, a_i} * {{WIDTH{1'b0}}, b_i};

    always_comb begin
        result_o = '0;
        ovf_o    = 1'b0;
        case (op_i)
            OP_ADD: begin
                result_o = sum[WIDTH-1:0];
                ovf_o    = sum[WIDTH];
            end
            OP_SUB: begin
                result_o = diff[WIDTH-1:0];
                ovf_o    = diff[WIDTH];
            end
            OP_MUL: begin
                result_o = prod[WIDTH-1:0];
                ovf_o    = |prod[2*WIDTH-1:WIDTH];
            end
            OP_AND:  result_o = a_i & b_i;
            OP_OR:   result_o = a_i | b_i;
            default: result_o = '0;
        endcase
    end

endmodule

// File: rtl/calc_key_engine.sv
// Two-operand keypad calculator driven by the grid cursor's key pulses.
// Define CALC_OVF_LOCK_EN to trap overflowing results in S_ERR until CLR.
module calc_key_engine
    import calc_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             key_valid,
    input  logic [4:0]       key_code,
    input  logic             base_dec,
    output logic             restriction,
    output logic [WIDTH-1:0] display_val,
    output logic [2:0]       op_pending,
    output logic             result_valid,
    output logic             overflow,
    output logic             busy
);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] display_val_q, display_val_d;
    op_t              op_pending_q, op_pending_d;
    op_t              chain_op_q, chain_op_d;
    logic             overflow_q, overflow_d;
    logic             result_valid_q, result_valid_d;
    logic             restriction_q, restriction_d;
    logic             entry_empty_q, entry_empty_d;

    key_dec_t         kd;
    logic             act;
    logic             digit_ok;
    logic             fits;
    logic [WIDTH-1:0] cur;
    logic [WIDTH+3:0] ext;
    logic [WIDTH-1:0] entry_val;
    logic [WIDTH-1:0] alu_r;
    logic             alu_ovf;

    assign busy = (state_q == S_CALC);
    assign kd   = decode_key(key_code);
    assign act  = key_valid & ~busy;
    assign cur  = (state_q == S_B) ? b_q : a_q;

    // Four spare bits catch any digit that would push the operand past 2^WIDTH-1.
    always_comb begin
        ext = '0;
        if (restriction_q)
            ext = ({4'b0, cur} * (WIDTH+4)'(10)) + (WIDTH+4)'(kd.digit);
        else
            ext = {cur, kd.digit};
    end

    assign entry_val = ext[WIDTH-1:0];
    assign fits      = (ext[WIDTH+3:WIDTH] == 4'd0);
    assign digit_ok  = kd.is_digit & ~(restriction_q & (kd.digit > 4'd9));

    calc_alu #(.WIDTH(WIDTH)) u_alu (
        .a_i      (a_q),
        .b_i      (b_q),
        .op_i     (op_pending_q),
        .result_o (alu_r),
        .ovf_o    (alu_ovf)
    );

    always_comb begin
        state_d        = state_q;
        a_d            = a_q;
        b_d            = b_q;
        display_val_d  = display_val_q;
        op_pending_d   = op_pending_q;
        chain_op_d     = chain_op_q;
        overflow_d     = overflow_q;
        result_valid_d = 1'b0;
        entry_empty_d  = entry_empty_q;
        // Base only follows the request before the first digit of operand A.
        restriction_d  = (state_q == S_A && entry_empty_q) ? base_dec : restriction_q;

        case (state_q)
            S_A: begin
                if (act) begin
                    if (digit_ok && fits) begin
                        a_d           = entry_val;
                        display_val_d = entry_val;
                        entry_empty_d = 1'b0;
                    end else if (kd.is_op) begin
                        op_pending_d  = kd.op;
                        b_d           = '0;
                        entry_empty_d = 1'b1;
                        state_d       = S_B;
                    end else if (kd.is_ce) begin
                        a_d           = '0;
                        display_val_d = '0;
                        entry_empty_d = 1'b1;
                    end
                end
            end
            S_B: begin
                if (act) begin
                    if (digit_ok && fits) begin
                        b_d           = entry_val;
                        display_val_d = entry_val;
                        entry_empty_d = 1'b0;
                    end else if (kd.is_op) begin
                        if (entry_empty_q) begin
                            op_pending_d = kd.op;
                        end else begin
                            chain_op_d = kd.op;
                            state_d    = S_CALC;
                        end
                    end else if (kd.is_exe) begin
                        state_d = S_CALC;
                    end else if (kd.is_ce) begin
                        b_d           = '0;
                        display_val_d = '0;
                        entry_empty_d = 1'b1;
                    end
                end
            end
            S_CALC: begin
                a_d            = alu_r;
                display_val_d  = alu_r;
                overflow_d     = alu_ovf;
                result_valid_d = 1'b1;
                state_d        = S_RES;
`ifdef CALC_OVF_LOCK_EN
                if (alu_ovf) begin
                    display_val_d = '1;
                    state_d       = S_ERR;
                end
`endif
            end
            S_RES: begin
                // A chained operator from S_B takes priority over any new key.
                if (chain_op_q != OP_NONE) begin
                    op_pending_d  = chain_op_q;
                    chain_op_d    = OP_NONE;
                    b_d           = '0;
                    entry_empty_d = 1'b1;
                    state_d       = S_B;
                end else if (act) begin
                    if (digit_ok) begin
                        a_d           = {{(WIDTH-4){1'b0}}, kd.digit};
                        display_val_d = {{(WIDTH-4){1'b0}}, kd.digit};
                        overflow_d    = 1'b0;
                        entry_empty_d = 1'b0;
                        state_d       = S_A;
                    end else if (kd.is_op) begin
                        op_pending_d  = kd.op;
                        b_d           = '0;
                        entry_empty_d = 1'b1;
                        state_d       = S_B;
                    end else if (kd.is_exe) begin
                        state_d = S_CALC;
                    end else if (kd.is_ce) begin
                        a_d           = '0;
                        display_val_d = '0;
                        entry_empty_d = 1'b1;
                        state_d       = S_A;
                    end
                end
            end
            S_ERR: begin
                state_d = S_ERR;
            end
            default: state_d = S_A;
        endcase

        if (act && kd.is_clr) begin
            state_d       = S_A;
            a_d           = '0;
            b_d           = '0;
            display_val_d = '0;
            op_pending_d  = OP_NONE;
            chain_op_d    = OP_NONE;
            overflow_d    = 1'b0;
            entry_empty_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= S_A;
            a_q            <= '0;
            b_q            <= '0;
            display_val_q  <= '0;
            op_pending_q   <= OP_NONE;
            chain_op_q     <= OP_NONE;
            overflow_q     <= 1'b0;
            result_valid_q <= 1'b0;
            restriction_q  <= 1'b0;
            entry_empty_q  <= 1'b1;
        end else begin
            state_q        <= state_d;
            a_q            <= a_d;
            b_q            <= b_d;
            display_val_q  <= display_val_d;
            op_pending_q   <= op_pending_d;
            chain_op_q     <= chain_op_d;
            overflow_q     <= overflow_d;
            result_valid_q <= result_valid_d;
            restriction_q  <= restriction_d;
            entry_empty_q  <= entry_empty_d;
        end
    end

    assign restriction  = restriction_q;
    assign display_val  = display_val_q;
    assign op_pending   = op_pending_q;
    assign result_valid = result_valid_q;
    assign overflow     = overflow_q;

endmodule

// File: tb/tb_calc_key_engine.sv
// Directed bench for calc_key_engine: results are checked by a scoreboard monitor
// on result_valid; entry-time values are checked directly from the stimulus.
module tb_calc_key_engine;

    localparam logic [4:0] K_ADD = 5'h10;
    localparam logic [4:0] K_MUL = 5'h11;
    localparam logic [4:0] K_EXE = 5'h13;
    localparam logic [4:0] K_SUB = 5'h14;
    localparam logic [4:0] K_OR  = 5'h15;
    localparam logic [4:0] K_CE  = 5'h16;
    localparam logic [4:0] K_CLR = 5'h17;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        key_valid = 1'b0;
    logic [4:0]  key_code = 5'h0;
    logic        base_dec = 1'b0;
    logic        restriction;
    logic [15:0] display_val;
    logic [2:0]  op_pending;
    logic        result_valid;
    logic        overflow;
    logic        busy;

    typedef struct packed {
        logic [15:0] val;
        logic        ovf;
    } exp_t;

    exp_t expq[$];
    int   checks = 0;
    int   errors = 0;

    calc_key_engine #(.WIDTH(16)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .key_valid    (key_valid),
        .key_code     (key_code),
        .base_dec     (base_dec),
        .restriction  (restriction),
        .display_val  (display_val),
        .op_pending   (op_pending),
        .result_valid (result_valid),
        .overflow     (overflow),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    // Called at a negedge; the key is held across exactly one rising edge.
    task automatic press(input logic [4:0] c);
        key_code  = c;
        key_valid = 1'b1;
        @(negedge clk);
        key_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic exe_expect(input logic [15:0] v, input logic o);
        expq.push_back('{val: v, ovf: o});
        press(K_EXE);
        idle(3);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n && result_valid) begin
                if (expq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_result: got 0x%0h expected none", display_val);
                end else begin
                    e = expq.pop_front();
                    check("result_val", {16'h0, display_val}, {16'h0, e.val});
                    check("result_ovf", {31'h0, overflow}, {31'h0, e.ovf});
                end
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1);
    end

    initial begin : stim
        idle(2);
        check("rst_display", {16'h0, display_val}, 32'h0);
        check("rst_op", {29'h0, op_pending}, 32'h0);
        check("rst_flags", {27'h0, restriction, result_valid, overflow, busy}, 32'h0);
        rst_n = 1'b1;
        idle(2);

        // hex 0x12 + 0x34
        press(5'h1); press(5'h2); press(K_ADD); press(5'h3); press(5'h4);
        check("b_entry", {16'h0, display_val}, 32'h34);
        check("op_add", {29'h0, op_pending}, 32'd1);
        exe_expect(16'h0046, 1'b0);
        press(K_CLR); idle(1);

        // CE clears only B; then repeat EXE borrows
        press(5'h5); press(K_SUB); press(5'h9); press(K_CE);
        check("ce_display", {16'h0, display_val}, 32'h0);
        press(5'h3);
        exe_expect(16'h0002, 1'b0);
        exe_expect(16'hFFFF, 1'b1);
        press(K_CLR); idle(1);
        check("clr_display", {16'h0, display_val}, 32'h0);
        check("clr_ovf", {31'h0, overflow}, 32'h0);

        // carry out of 0xFFFF + 1
        press(5'hF); press(5'hF); press(5'hF); press(5'hF); press(K_ADD); press(5'h1);
`ifdef CALC_OVF_LOCK_EN
        exe_expect(16'hFFFF, 1'b1);
        press(5'h5);
        check("err_digit_ignored", {16'h0, display_val}, 32'hFFFF);
        check("err_ovf_held", {31'h0, overflow}, 32'h1);
`else
        exe_expect(16'h0000, 1'b1);
        press(5'h5);
        check("res_digit", {16'h0, display_val}, 32'h5);
        check("res_digit_ovf", {31'h0, overflow}, 32'h0);
`endif
        press(K_CLR); idle(1);
        check("clr_after_ovf", {16'h0, display_val}, 32'h0);

        // fifth hex digit would overflow 16 bits
        press(5'h1); press(5'h2); press(5'h3); press(5'h4); press(5'h5);
        check("hex_digit_ovf", {16'h0, display_val}, 32'h1234);
        press(K_CLR); idle(1);

        // key during busy is dropped, then EXE repeats 5+3
        press(5'h2); press(K_ADD); press(5'h3);
        expq.push_back('{val: 16'h0005, ovf: 1'b0});
        press(K_EXE);
        check("busy_high", {31'h0, busy}, 32'h1);
        press(5'h7);
        idle(2);
        check("busy_drop", {16'h0, display_val}, 32'h5);
        exe_expect(16'h0008, 1'b0);
        press(K_CLR); idle(1);

        // chaining: 2+3 then * acts as EXE, then *4
        press(5'h2); press(K_ADD); press(5'h3);
        expq.push_back('{val: 16'h0005, ovf: 1'b0});
        press(K_MUL);
        idle(3);
        check("chain_op", {29'h0, op_pending}, 32'd3);
        press(5'h4);
        exe_expect(16'h0014, 1'b0);
        press(K_CLR); idle(1);

        // decimal: 12 * 10, hex digit A ignored
        base_dec = 1'b1;
        idle(2);
        check("restriction_dec", {31'h0, restriction}, 32'h1);
        press(5'h1); press(5'h2); press(5'hA);
        check("dec_hex_ignored", {16'h0, display_val}, 32'd12);
        press(K_MUL); press(5'h1); press(5'h0);
        exe_expect(16'h0078, 1'b0);
        press(K_CLR); idle(1);

        press(5'h6); press(5'h5); press(5'h5); press(5'h3); press(5'h6);
        check("dec_digit_ovf", {16'h0, display_val}, 32'd6553);
        press(K_CLR); idle(1);

        // base locked once A has a digit
        press(5'h7);
        base_dec = 1'b0;
        idle(2);
        check("base_locked", {31'h0, restriction}, 32'h1);
        press(K_CLR); idle(1);
        check("base_reload", {31'h0, restriction}, 32'h0);

        // async reset in S_B
        press(5'h7); press(K_OR); press(5'h3);
        check("or_op", {29'h0, op_pending}, 32'd5);
        check("or_b", {16'h0, display_val}, 32'h3);
        rst_n = 1'b0;
        @(posedge clk); #1;
        check("midrst_display", {16'h0, display_val}, 32'h0);
        check("midrst_op", {29'h0, op_pending}, 32'h0);
        check("midrst_flags", {27'h0, restriction, result_valid, overflow, busy}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        idle(5);

        check("pending_results", expq.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
